// File: rtl/cordic_multiply_if.sv
// Operand/result bundle for the linear-CORDIC multiplier: start request with
// operands on the master side, registered result and status on the slave side.
interface cordic_multiply_if #(
    parameter int W = 32
) ();
    logic                start;
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    logic signed [W-1:0] product;
    logic                busy;
    logic                done;
    logic                err;
    logic                ovf;

    modport master (
        output start, a, b,
        input  product, busy, done, err, ovf
    );

    modport slave (
        input  start, a, b,
        output product, busy, done, err, ovf
    );
endinterface

// File: rtl/cordic_multiply.sv
// Iterative linear-mode CORDIC in rotation mode: drives Z to zero while
// accumulating Y = X * Z, one micro-rotation per clock. Signed fixed point with
// FLOAT_SIZE fractional bits; out-of-range multiplier flags err, and a result
// that does not fit the word saturates and flags ovf.
module cordic_multiply #(
    parameter int FLOAT_SIZE = 24,
    parameter int INT_SIZE   = 8
) (
    input logic              clk,
    input logic              rst,
    cordic_multiply_if.slave bus
);
    localparam int W     = INT_SIZE + FLOAT_SIZE;
    localparam int CNT_W = $clog2(FLOAT_SIZE + 1);

    localparam logic [CNT_W-1:0]  LAST_IT = CNT_W'(FLOAT_SIZE);
    localparam logic [W-1:0]      ONE     = W'(1) << FLOAT_SIZE;
    // 2.0 needs W+1 bits when INT_SIZE is 2, so the range check is done wide.
    localparam logic signed [W:0] TWO     = (W+1)'(2) << FLOAT_SIZE;
    localparam logic [W-1:0]      SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]      SAT_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic signed [W-1:0] x_q, x_d;
    logic signed [W-1:0] z_q, z_d;
    logic signed [W:0]   y_q, y_d;       // one guard bit for overflow detection
    logic [CNT_W-1:0]    i_q, i_d;
    logic [W-1:0]        product_q, product_d;
    logic                err_q, err_d;
    logic                ovf_q, ovf_d;

    logic signed [W:0]   x_ext;
    logic signed [W:0]   x_sh;
    logic signed [W-1:0] z_step;

    // Multiplier must satisfy -2.0 < b < 2.0 for the iteration to converge.
    function automatic logic b_in_range(input logic signed [W-1:0] v);
        logic signed [W:0] ve;
        ve = {v[W-1], v};
        return (ve < TWO) && (ve > -TWO);
    endfunction

    // Y fits the output word when the guard bit equals the word sign bit.
    function automatic logic fits_w(input logic signed [W:0] v);
        return v[W] == v[W-1];
    endfunction

    // Clamp the guarded accumulator to the nearest representable word.
    function automatic logic [W-1:0] saturate(input logic signed [W:0] v);
        if (fits_w(v)) begin
            return v[W-1:0];
        end else if (v[W]) begin
            return SAT_MIN;
        end else begin
            return SAT_MAX;
        end
    endfunction

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            z_q       <= '0;
            y_q       <= '0;
            i_q       <= '0;
            product_q <= '0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            z_q       <= z_d;
            y_q       <= y_d;
            i_q       <= i_d;
            product_q <= product_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
        end
    end

    // Next-state: accept in IDLE, run FLOAT_SIZE+1 rotations, one DONE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = b_in_range(bus.b) ? S_ITER : S_DONE;
                end
            end
            S_ITER: begin
                if (i_q == LAST_IT) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: operand capture, micro-rotation and result/flag update.
    always_comb begin
        x_d       = x_q;
        z_d       = z_q;
        y_d       = y_q;
        i_d       = i_q;
        product_d = product_q;
        err_d     = err_q;
        ovf_d     = ovf_q;
        x_ext     = {x_q[W-1], x_q};
        x_sh      = x_ext >>> i_q;
        z_step    = $signed(ONE >> i_q);
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    x_d   = bus.a;
                    z_d   = bus.b;
                    y_d   = '0;
                    i_d   = '0;
                    err_d = 1'b0;
                    ovf_d = 1'b0;
                    if (!b_in_range(bus.b)) begin
                        err_d     = 1'b1;
                        product_d = '0;
                    end
                end
            end
            S_ITER: begin
                // Rotate toward Z = 0; the sign of Z picks the direction.
                if (!z_q[W-1]) begin
                    y_d = y_q + x_sh;
                    z_d = z_q - z_step;
                end else begin
                    y_d = y_q - x_sh;
                    z_d = z_q + z_step;
                end
                i_d = i_q + CNT_W'(1);
                if (i_q == LAST_IT) begin
                    product_d = saturate(y_d);
                    ovf_d     = !fits_w(y_d);
                end
            end
            default: ;
        endcase
    end

    // Outputs: handshake decoded from state, results straight from registers.
    always_comb begin
        bus.busy    = (state_q != S_IDLE);
        bus.done    = (state_q == S_DONE);
        bus.product = product_q;
        bus.err     = err_q;
        bus.ovf     = ovf_q;
    end
endmodule

// File: tb/tb_cordic_multiply.sv
// Directed and randomized bench for cordic_multiply; expected results come from
// exact integer multiplication with the documented tolerance and saturation.
module tb_cordic_multiply;
    localparam int FS  = 24;
    localparam int IS  = 8;
    localparam int W   = FS + IS;
    localparam int LAT = FS + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cordic_multiply_if #(.W(W)) bus ();

    cordic_multiply #(.FLOAT_SIZE(FS), .INT_SIZE(IS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic signed [W-1:0] last_prod;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input logic signed [W-1:0] obs, input longint exp, input longint tol);
        longint diff;
        checks++;
        diff = longint'(obs) - exp;
        if (diff < 0) diff = -diff;
        assert (!$isunknown(obs) && diff <= tol) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d (+/-%0d)", tag, obs, exp, tol);
        end
    endtask

    // Reference: range check, exact product floored to FLOAT_SIZE fraction, clamp.
    task automatic model(input int av, input int bv, output longint ep, output bit ee, output bit eo, output longint tol);
        longint ideal, mag;
        ee = 1'b0; eo = 1'b0; ep = 0; tol = 0;
        if (longint'(bv) >= (64'sd2 <<< FS) || longint'(bv) <= -(64'sd2 <<< FS)) begin
            ee = 1'b1;
            return;
        end
        ideal = (longint'(av) * longint'(bv)) >>> FS;
        mag   = (av < 0) ? -longint'(av) : longint'(av);
        tol   = FS + 2 + ((mag + (64'sd1 <<< FS) - 1) >>> FS);
        if (ideal > 64'sd2147483647) begin
            ep = 64'sd2147483647; eo = 1'b1; tol = 0;
        end else if (ideal < -64'sd2147483648) begin
            ep = -64'sd2147483648; eo = 1'b1; tol = 0;
        end else begin
            ep = ideal;
        end
    endtask

    // One transaction; optional extra start pulses while busy must be ignored.
    task automatic run_op(input int av, input int bv, input bit pulse,
                          output logic signed [W-1:0] prod, output logic e, output logic o,
                          output int lat, output bit busy_ok);
        lat = -1; busy_ok = 1'b1;
        @(negedge clk);
        bus.start = 1'b1; bus.a = av; bus.b = bv;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (bus.done === 1'b1) begin
                lat = n - 1; prod = bus.product; e = bus.err; o = bus.ovf;
                break;
            end
            bus.start = pulse && (n == 5 || n == 24 || n == 25);
        end
        bus.start = 1'b0;
        @(negedge clk);
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic do_check(input string tag, input int av, input int bv, input bit pulse);
        logic signed [W-1:0] p;
        logic e, o;
        int lat;
        bit bok, ee, eo;
        longint ep, tol;
        model(av, bv, ep, ee, eo, tol);
        run_op(av, bv, pulse, p, e, o, lat, bok);
        chk({tag, "_lat"}, lat, ee ? 0 : LAT);
        chk({tag, "_busy"}, bok, 1);
        chk({tag, "_err"}, e, ee);
        chk({tag, "_ovf"}, o, eo);
        if (ee || eo) chk({tag, "_prod"}, p, ep);
        else          chk_near({tag, "_prod"}, p, ep, tol);
        last_prod = p;
    endtask

    initial begin
        int av, bv;
        bit seen_done;
        int lat;
        rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_prod", bus.product, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_ovf", bus.ovf, 0);
        rst = 1'b1;

        do_check("m3x1p5", 32'h03000000, 32'h01800000, 1'b0);
        do_check("neg", 32'hFD800000, 32'h00C00000, 1'b0);
        do_check("b_p2", 32'h01234567, 32'h02000000, 1'b0);
        do_check("b_m2", 32'h05000000, 32'hFE000000, 1'b0);
        do_check("clr_err", 32'h00800000, 32'h01000000, 1'b0);
        do_check("a_zero", 0, 32'h01400000, 1'b0);
        chk("a_zero_exact", last_prod, 0);
        do_check("b_zero", 32'h05000000, 0, 1'b0);
        do_check("sat_pos", 32'h64000000, 32'h01E66666, 1'b0);
        do_check("sat_neg", 32'h9C000000, 32'h01E66666, 1'b0);
        do_check("ign_start", 32'h02400000, 32'hFF400000, 1'b1);

        for (int k = 0; k < 12; k++) begin
            av = int'($urandom_range(32'd2013265920)) - 1006632960;
            if (k % 4 == 3) begin
                bv = int'($urandom_range(127 << 24, 2 << 24));
                if ($urandom_range(1) == 1) bv = -bv;
            end else begin
                bv = int'($urandom_range(32'd67108862)) - 33554431;
            end
            do_check($sformatf("rnd%0d", k), av, bv, k[0]);
        end

        // Reset in the middle of an operation.
        do_check("pre_rst", 32'h03000000, 32'h01000000, 1'b0);
        @(negedge clk);
        bus.start = 1'b1; bus.a = 32'h05000000; bus.b = 32'h01400000;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_prod", bus.product, 0);
        chk("arst_err", bus.err, 0);
        chk("arst_ovf", bus.ovf, 0);
        seen_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done !== 1'b0) seen_done = 1'b1;
        end
        rst = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen_done = 1'b1;
        end
        chk("arst_no_done", seen_done, 0);
        do_check("post_rst", 32'h01000000, 32'h01000000, 1'b0);

        // start held high: back-to-back results with a single IDLE gap cycle.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 32'h02000000; bus.b = 32'h00800000;
        for (int r = 0; r < 2; r++) begin
            lat = -1;
            for (int n = 1; n <= 40; n++) begin
                @(negedge clk);
                if (bus.done === 1'b1) begin
                    lat = n - 1;
                    break;
                end
            end
            chk($sformatf("b2b_lat%0d", r), lat, LAT);
            chk_near($sformatf("b2b_prod%0d", r), bus.product, 64'sd16777216, 64'sd28);
            if (r == 1) bus.start = 1'b0;
            @(negedge clk);
            chk($sformatf("b2b_gap%0d", r), bus.busy, 0);
        end
        @(negedge clk);
        chk("b2b_stop", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
